// File: rtl/lap_stack_ctrl_if.sv
// lap_stack_ctrl_if: push/pop bus between the lap sequencer and its LIFO memory
interface lap_stack_ctrl_if #(parameter int WIDTH = 12);
    logic             mem_write;
    logic             mem_read;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] mem_out;
    modport master (output mem_write, mem_read, mem_data, input mem_out);
    modport slave (input mem_write, mem_read, mem_data, output mem_out);
endinterface

// File: rtl/lap_stack_ctrl.sv
// lap_stack_ctrl: turns lap/recall/clear pulses into push/pop strobes for the lap LIFO and holds recalled values on the display
module lap_stack_ctrl #(
    parameter int WIDTH       = 12,
    parameter int DEPTH       = 3,
    parameter int SHOW_CYCLES = 10
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [WIDTH-1:0]           count_in_i,
    input  logic                       lap_req_i,
    input  logic                       recall_req_i,
    input  logic                       clr_req_i,
    lap_stack_ctrl_if.master           bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       busy_o,
    output logic                       disp_sel_o,
    output logic [WIDTH-1:0]           disp_value_o,
    output logic                       err_full_o,
    output logic                       err_empty_o
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(SHOW_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, PUSH, POP, SHOW, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d, disp_q, disp_d;
    logic             err_full_q, err_full_d, err_empty_q, err_empty_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            disp_q      <= '0;
            err_full_q  <= 1'b0;
            err_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            disp_q      <= disp_d;
            err_full_q  <= err_full_d;
            err_empty_q <= err_empty_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        disp_d      = disp_q;
        err_full_d  = 1'b0;
        err_empty_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                end else if (lap_req_i) begin
                    err_full_d = full_o;
                    data_d     = full_o ? data_q : count_in_i;
                    state_d    = full_o ? IDLE : PUSH;
                end else if (recall_req_i) begin
                    err_empty_d = empty_o;
                    state_d     = empty_o ? IDLE : POP;
                end
            end
            PUSH: begin
                occ_d   = occ_q + OW'(1);
                state_d = IDLE;
            end
            POP: begin
                occ_d   = occ_q - OW'(1);
                disp_d  = bus.mem_out;
                cnt_d   = CW'(SHOW_CYCLES);
                state_d = SHOW;
            end
            SHOW: begin
                cnt_d   = clr_req_i ? '0 : cnt_q - CW'(1);
                state_d = clr_req_i ? CLEAR : (cnt_q == CW'(1) ? IDLE : SHOW);
            end
            CLEAR: begin
                // one pop per stored entry, then one idle-strobe cycle before leaving
                occ_d   = empty_o ? occ_q : occ_q - OW'(1);
                state_d = empty_o ? IDLE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign full_o        = occ_q == OW'(DEPTH);
    assign empty_o       = occ_q == '0;
    assign occupancy_o   = occ_q;
    assign busy_o        = state_q != IDLE;
    assign disp_sel_o    = state_q == SHOW;
    assign disp_value_o  = disp_q;
    assign err_full_o    = err_full_q;
    assign err_empty_o   = err_empty_q;
    assign bus.mem_write = state_q == PUSH;
    assign bus.mem_read  = state_q == POP || (state_q == CLEAR && !empty_o);
    assign bus.mem_data  = data_q;
endmodule

// File: tb/tb_lap_stack_ctrl.sv
// tb_lap_stack_ctrl: scoreboard bench for lap_stack_ctrl with a behavioural 3-entry LIFO memory
module tb_lap_stack_ctrl;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic [W-1:0] count_in = '0;
    logic         lap = 1'b0, recall = 1'b0, clr = 1'b0;
    logic [1:0]   occupancy;
    logic         full, empty, busy, disp_sel, err_full, err_empty;
    logic [W-1:0] disp_value;
    int           checks = 0, errors = 0;
    logic [W-1:0] wq[$], rq[$];
    logic [W-1:0] mem[3];
    logic [1:0]   sp;
    logic         disp_sel_prev;

    lap_stack_ctrl_if #(.WIDTH(W)) bus();

    lap_stack_ctrl #(.WIDTH(W), .DEPTH(3), .SHOW_CYCLES(10)) dut (
        .clk(clk), .nrst(nrst), .count_in_i(count_in), .lap_req_i(lap),
        .recall_req_i(recall), .clr_req_i(clr), .bus(bus),
        .occupancy_o(occupancy), .full_o(full), .empty_o(empty), .busy_o(busy),
        .disp_sel_o(disp_sel), .disp_value_o(disp_value),
        .err_full_o(err_full), .err_empty_o(err_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // behavioural memory: top-of-stack visible combinationally
    always @(posedge clk or negedge nrst) begin
        if (!nrst) sp <= 2'd0;
        else if (bus.mem_write && sp < 2'd3) begin
            mem[sp] <= bus.mem_data;
            sp <= sp + 2'd1;
        end else if (bus.mem_read && sp > 2'd0) sp <= sp - 2'd1;
    end
    always_comb bus.mem_out = sp > 2'd0 ? mem[sp - 2'd1] : '0;

    always @(negedge clk) begin
        if (nrst) begin
            check("strobe_excl", 32'(bus.mem_write & bus.mem_read), 0);
            if (bus.mem_write) begin
                check("write_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) check("mem_data", bus.mem_data, wq.pop_front());
            end
            if (disp_sel && !disp_sel_prev) begin
                check("recall_expected", 32'(rq.size() > 0), 1);
                if (rq.size() > 0) check("disp_value", disp_value, rq.pop_front());
            end
        end
        disp_sel_prev <= nrst & disp_sel;
    end

    task automatic lap_t(input logic [W-1:0] v, input bit accept);
        @(negedge clk);
        count_in = v;
        lap = 1'b1;
        if (accept) wq.push_back(v);
        @(negedge clk);
        lap = 1'b0;
        check("lap_write", bus.mem_write, accept);
        check("lap_err_full", err_full, !accept);
        @(negedge clk);
        check("err_full_pulse", err_full, 0);
    endtask

    task automatic clear_t();
        int n = 0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("clear_done", busy, 0);
        check("clear_occ", occupancy, 0);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_occ"}, occupancy, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_disp_sel"}, disp_sel, 0);
        check({tag, "_disp_value"}, disp_value, 0);
        check({tag, "_wr"}, bus.mem_write, 0);
        check({tag, "_rd"}, bus.mem_read, 0);
        check({tag, "_data"}, bus.mem_data, 0);
        check({tag, "_errs"}, {err_full, err_empty}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, reads;
        repeat (2) @(negedge clk);
        check_idle_reset("reset");
        nrst = 1'b1;

        lap_t(12'h005, 1'b1);
        check("t1_occ", occupancy, 1);
        check("t1_empty", empty, 0);

        clear_t();
        lap_t(12'h010, 1'b1);
        lap_t(12'h020, 1'b1);
        lap_t(12'h030, 1'b1);
        check("t2_full", full, 1);
        lap_t(12'h040, 1'b0);
        check("t2_occ", occupancy, 3);
        check("t2_full_after", full, 1);

        @(negedge clk);
        recall = 1'b1;
        rq.push_back(12'h030);
        @(negedge clk);
        recall = 1'b0;
        check("t3_pop_rd", bus.mem_read, 1);
        check("t3_pop_disp_sel", disp_sel, 0);
        @(negedge clk);
        check("t3_rd_once", bus.mem_read, 0);
        n = 0;
        count_in = 12'h0BB;
        while (disp_sel && n < 20) begin
            lap = (n == 3);
            @(negedge clk);
            n++;
        end
        lap = 1'b0;
        check("t3_show_len", n, 10);
        check("t3_occ", occupancy, 2);
        check("t3_disp_keep", disp_value, 12'h030);
        check("t3_busy", busy, 0);

        clear_t();
        @(negedge clk);
        recall = 1'b1;
        @(negedge clk);
        recall = 1'b0;
        check("t4_err_empty", err_empty, 1);
        check("t4_rd", bus.mem_read, 0);
        check("t4_disp_sel", disp_sel, 0);
        @(negedge clk);
        check("t4_err_pulse", err_empty, 0);
        check("t4_disp_sel2", disp_sel, 0);

        lap_t(12'h111, 1'b1);
        lap_t(12'h222, 1'b1);
        lap_t(12'h333, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        lap = 1'b1;
        count_in = 12'h0AA;
        @(negedge clk);
        clr = 1'b0;
        lap = 1'b0;
        reads = 0;
        n = 0;
        while (busy && n < 10) begin
            reads += int'(bus.mem_read);
            @(negedge clk);
            n++;
        end
        check("t5_reads", reads, 3);
        check("t5_cycles", n, 4);
        check("t5_occ", occupancy, 0);
        check("t5_busy", busy, 0);

        lap_t(12'h321, 1'b1);
        @(negedge clk);
        recall = 1'b1;
        rq.push_back(12'h321);
        @(negedge clk);
        recall = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_in_show", disp_sel, 1);
        #2 nrst = 1'b0;
        #1 check_idle_reset("t6_show_rst");
        @(negedge clk);
        nrst = 1'b1;

        lap_t(12'hA01, 1'b1);
        lap_t(12'hA02, 1'b1);
        lap_t(12'hA03, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("t6_clr2_rd", bus.mem_read, 1);
        check("t6_clr2_occ", occupancy, 2);
        #2 nrst = 1'b0;
        #1 check_idle_reset("t6_clear_rst");
        @(negedge clk);
        nrst = 1'b1;
        lap_t(12'h123, 1'b1);
        check("t6_relap_occ", occupancy, 1);
        check("t6_relap_empty", empty, 0);

        repeat (2) @(negedge clk);
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
